// File: rtl/latch_out_debounce_edge_if.sv
// Signal bundle between the latch-output debouncer and its consumer.
// The slave side is the debouncer itself; the master side drives the
// latch level and the counter clear, and observes the debounced results.
interface latch_out_debounce_edge_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 d_in;
    logic                 cnt_clr;
    logic                 q_stable;
    logic                 rise;
    logic                 fall;
    logic                 glitch;
    logic [CNT_WIDTH-1:0] toggle_cnt;
    logic                 cnt_sat;

    modport slave (
        input  d_in, cnt_clr,
        output q_stable, rise, fall, glitch, toggle_cnt, cnt_sat
    );

    modport master (
        output d_in, cnt_clr,
        input  q_stable, rise, fall, glitch, toggle_cnt, cnt_sat
    );
endinterface

// File: rtl/latch_out_debounce_edge.sv
// Latch-output debouncer.
// The asynchronous latch Q is brought into the clk domain through a
// synchronizer chain. A new level is accepted only once it has been seen
// on STABLE_CYCLES consecutive synchronized samples. Accepted edges produce
// one-cycle rise/fall pulses and bump a saturating transition counter.
// A pending level change that is abandoned produces a one-cycle glitch pulse.
module latch_out_debounce_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    latch_out_debounce_edge_if.slave  bus
);
    localparam int                   DCNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [DCNT_W-1:0]    DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0]    DCNT_LAST = DCNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q, state_d;
    logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
    logic                   rise_d, fall_d, glitch_d;

    logic                   q_stable_q, rise_q, fall_q, glitch_q;
    logic [CNT_WIDTH-1:0]   toggle_cnt_q;
    logic                   cnt_sat_q;

    // Synchronizer chain: bit 0 captures d_in, each later bit copies the one before.
    // NOTE: every flop in the block, including the whole synchronizer, is cleared
    // by the asynchronous reset so the outputs are defined without any clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment lets each stage take the previous
            // stage's old value, which is what makes this a shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.d_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce state and sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next state, sample count and pulse requests from the synchronized level.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        unique case (state_q)
            LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    dcnt_d  = DCNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d  = LOW;
                    dcnt_d   = '0;
                    glitch_d = 1'b1;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = HIGH;
                    dcnt_d  = '0;
                    rise_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    dcnt_d  = DCNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d  = HIGH;
                    dcnt_d   = '0;
                    glitch_d = 1'b1;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = LOW;
                    dcnt_d  = '0;
                    fall_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                dcnt_d  = '0;
            end
        endcase
    end

    // Registered level and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_stable_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            glitch_q   <= 1'b0;
        end else begin
            q_stable_q <= (state_d == HIGH) || (state_d == WAIT_LOW);
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            glitch_q   <= glitch_d;
        end
    end

    // Saturating transition counter; a clear on the same edge as an increment wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt_q <= '0;
            cnt_sat_q    <= 1'b0;
        end else if (bus.cnt_clr) begin
            toggle_cnt_q <= '0;
            cnt_sat_q    <= 1'b0;
        end else if ((rise_d || fall_d) && (toggle_cnt_q != CNT_MAX)) begin
            toggle_cnt_q <= toggle_cnt_q + 1'b1;
            cnt_sat_q    <= (toggle_cnt_q == CNT_MAX - 1'b1);
        end
    end

    assign bus.q_stable   = q_stable_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.glitch     = glitch_q;
    assign bus.toggle_cnt = toggle_cnt_q;
    assign bus.cnt_sat    = cnt_sat_q;
endmodule

// File: doc/latch_out_debounce_edge.md
Name: latch_out_debounce_edge

Overview:
- Downstream consumer of the clocked D-latch output (Q) in the storage-element chain.
- Brings the latch output into the system clock domain through a synchronizer chain.
- Debounces it so only levels held for STABLE_CYCLES consecutive samples are accepted.
- Emits one-cycle rise/fall pulses plus a saturating transition counter, so the latch's delayed and glitchy output can be consumed safely by synchronous logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range >=2.
- STABLE_CYCLES, 4, consecutive equal synchronized samples required to accept a new level; legal range 2..255.
- CNT_WIDTH, 8, width of transition counter; legal range >=2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_in  in  1  latch Q output; asynchronous to clk.
- cnt_clr  in  1  synchronous clear of toggle_cnt and cnt_sat.
- q_stable  out  1  debounced, synchronized level.
- rise  out  1  one-cycle pulse when q_stable goes 0->1.
- fall  out  1  one-cycle pulse when q_stable goes 1->0.
- glitch  out  1  one-cycle pulse when a pending level change is abandoned.
- toggle_cnt  out  CNT_WIDTH  number of accepted transitions, saturating.
- cnt_sat  out  1  high while toggle_cnt is at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-wait):
  - sync chain = 0; FSM = LOW; debounce counter = 0.
  - q_stable, rise, fall, glitch, toggle_cnt, cnt_sat all = 0.
  - Release takes effect on the first rising edge with rst_n=1.
- Synchronizer: sync[0] <= d_in, sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1]. No logic between stages.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. q_stable = 1 in HIGH and WAIT_LOW, else 0 (registered).
  - LOW: s=1 -> WAIT_HIGH, dcnt=1; else stay.
  - WAIT_HIGH: s=0 -> LOW, glitch=1 next cycle. s=1 and dcnt=STABLE_CYCLES-1 -> HIGH, rise=1. Otherwise dcnt+1.
  - HIGH / WAIT_LOW: mirror of the above with s inverted, producing fall instead of rise.
- Latency: if d_in is first captured at edge n and held, q_stable and the rise/fall pulse update at edge n+SYNC_STAGES+STABLE_CYCLES-1. With defaults this is edge n+5.
- Pulse rules:
  - rise, fall and glitch are each high exactly one cycle.
  - rise and fall are never high together.
  - glitch is never high in the same cycle as rise or fall.
- A d_in pulse shorter than STABLE_CYCLES synchronized samples never changes q_stable. It produces a glitch pulse only if it reached s.
- Counter:
  - Each rise or fall increments toggle_cnt in the same cycle the pulse is asserted.
  - At all-ones the counter holds; cnt_sat = (toggle_cnt == all-ones).
  - cnt_clr=1 sets toggle_cnt=0 and cnt_sat=0 on the next edge.
  - If cnt_clr coincides with an increment, clear wins and the result is 0.
- The debounce counter (dcnt) never exceeds STABLE_CYCLES-1. No wrap-around is possible.
- Outputs are all registered; no combinational path from d_in to any output.

Test Plan:
- Reset: assert rst_n=0 mid-run with FSM in WAIT_HIGH -> all outputs 0 immediately, with no clock edge needed. After release with d_in=0, outputs stay 0.
- Clean rise (defaults): d_in 0->1 before edge n, held -> q_stable=1 and rise=1 at edge n+5. rise=0 at n+6; toggle_cnt=1.
- Glitch: d_in high for exactly 2 clock periods, then low -> q_stable stays 0, rise never asserts. glitch=1 for one cycle; toggle_cnt unchanged.
- Clean fall after rise: d_in 1->0 held -> fall=1 and q_stable=0 five edges after capture; toggle_cnt=2.
- Saturation (CNT_WIDTH=3): 9 clean transitions -> toggle_cnt reaches 7 after the 7th and stays 7. cnt_sat=1 from the 7th transition on.
- Clear priority: assert cnt_clr in the same cycle as a rise pulse -> toggle_cnt=0 and cnt_sat=0 next cycle. q_stable still =1.
